// File: rtl/deinter_frame_buffer.sv
// deinter_frame_buffer: tags deinterleaved symbols with block/frame position and buffers them in a FWFT FIFO
module deinter_frame_buffer #(
  parameter int DW            = 11,
  parameter int BLK_LEN       = 1536,
  parameter int BLK_PER_FRAME = 8,
  parameter int DEPTH         = 16,
  parameter int AW            = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_en,
  output logic [DW-1:0] dout,
  output logic          dout_sof,
  output logic          dout_eof,
  output logic          dout_last,
  output logic [2:0]    dout_blk,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          overflow,
  output logic [AW:0]   fifo_level
);
  localparam int SW = $clog2(BLK_LEN);
  localparam int EW = DW + 5;
  localparam logic [SW-1:0] SYM_LAST = SW'(BLK_LEN - 1);
  localparam logic [2:0] BLK_LAST = 3'(BLK_PER_FRAME - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_sym_cnt;
  logic [2:0]    r_blk_cnt;
  logic          r_overflow;
  logic          w_pop, w_push, w_sym_wrap;
  logic [EW-1:0] w_entry, w_head;
  assign w_pop      = (r_count != '0) & dout_ready;
  assign w_push     = din_en & ((r_count != FULL) | w_pop);
  assign w_sym_wrap = r_sym_cnt == SYM_LAST;
  assign w_entry    = {din, r_sym_cnt == '0, w_sym_wrap, r_blk_cnt};
  assign w_head     = r_mem[r_rd_ptr];
  assign dout       = w_head[EW-1:5];
  assign dout_sof   = w_head[4];
  assign dout_eof   = w_head[3];
  assign dout_blk   = w_head[2:0];
  assign dout_last  = dout_eof & (dout_blk == BLK_LAST);
  assign dout_valid = r_count != '0;
  assign overflow   = r_overflow;
  assign fifo_level = r_count;
  // Storage is cleared on reset so the head reads 0 before the first write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sym_cnt  <= '0;
      r_blk_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= (w_push & ~w_pop) ? r_count + 1'b1 :
                 (w_pop & ~w_push) ? r_count - 1'b1 : r_count;
      if (din_en) begin
        r_sym_cnt <= w_sym_wrap ? '0 : r_sym_cnt + 1'b1;
        if (w_sym_wrap) r_blk_cnt <= (r_blk_cnt == BLK_LAST) ? '0 : r_blk_cnt + 1'b1;
        if (!w_push) r_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: doc/deinter_frame_buffer.md
Name: deinter_frame_buffer

Overview:
Downstream stage of the deinterleaver. Accepts the 11-bit deinterleaved soft-symbol stream, which arrives with an enable and no backpressure. Tags each symbol with block/frame position: 1536-symbol blocks, 8 blocks per 12288-symbol frame. Buffers symbols in a small FIFO and presents them to the decoder through a valid/ready handshake.

Parameters:
DW, 11, symbol width
BLK_LEN, 1536, symbols per block
BLK_PER_FRAME, 8, blocks per frame
DEPTH, 16, FIFO entries (power of 2)
AW, 4, log2(DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
din  in  DW  deinterleaved symbol
din_en  in  1  din valid this cycle (no backpressure possible)
dout  out  DW  head-of-FIFO symbol
dout_sof  out  1  head symbol is index 0 of a block
dout_eof  out  1  head symbol is index BLK_LEN-1 of a block
dout_last  out  1  dout_eof and dout_blk == BLK_PER_FRAME-1
dout_blk  out  3  block index of head symbol, 0..7
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  consumer accepts head this cycle
overflow  out  1  sticky: a symbol was dropped
fifo_level  out  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0 at clk edge): wr_ptr, rd_ptr, count, sym_cnt, blk_cnt, overflow all 0. dout_valid=0, fifo_level=0. dout, dout_sof, dout_eof, dout_last, dout_blk read 0. FIFO memory contents are don't-care.
- Position counters advance on every din_en=1, including dropped symbols, so tags stay aligned with the upstream stream.
  - sym_cnt increments; at BLK_LEN-1 it wraps to 0 and blk_cnt increments.
  - blk_cnt wraps BLK_PER_FRAME-1 -> 0.
- Entry stored = {din, sof=(sym_cnt==0), eof=(sym_cnt==BLK_LEN-1), blk_cnt}, taken from the pre-increment counter values.
- pop = dout_valid & dout_ready.
- push = din_en & (count<DEPTH | pop). A write into a full FIFO is allowed when a pop occurs in the same cycle.
- Drop when din_en & count==DEPTH & !pop: the symbol is discarded, overflow is set to 1, and overflow holds until reset.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. fifo_level = count.
- Output is first-word-fall-through from registered storage. Outputs show the entry at rd_ptr; dout_valid = (count != 0).
- Latency: a symbol pushed at edge N appears on dout with dout_valid=1 after edge N. There is no same-cycle bypass, so push into an empty FIFO gives valid only from the next cycle.
- When dout_valid=0, dout and the tags hold stale values; the consumer must ignore them.
- Pointers are AW bits and wrap naturally modulo DEPTH.
- Pop with dout_ready=1 while empty has no effect.
- Reset mid-block: counters return to 0, so the next din_en symbol is tagged sof with blk 0. FIFO contents are discarded.
- Ordering is strict FIFO; no reordering and no duplication.

Test Plan:
- Reset: hold rst=0 for 2 cycles with din_en=1 -> dout_valid=0, fifo_level=0, overflow=0. After rst=1, the first symbol is tagged sof=1, blk=0.
- Streaming: dout_ready=1, 1536 symbols din=0..1535 every cycle -> dout equals din delayed 1 cycle. sof only on 0, eof only on 1535, blk=0 throughout, fifo_level<=1.
- Frame wrap: stream 12288 symbols, then 1 more, with ready=1 -> eof with blk=7 gives dout_last=1 exactly once. Symbol 12289 is sof=1, blk=0.
- Backpressure: dout_ready=0, push 17 symbols 100..116 -> fifo_level=16, overflow=1 after the 17th. Releasing ready drains exactly 100..115 in order.
- Full plus simultaneous events: FIFO full and dout_ready=1 with din_en=1 for 20 cycles -> level stays 16, no drop, overflow stays 0, order preserved.
- Mid-block reset: reset after 700 symbols, then resume -> next output has sof=1, blk=0. No pre-reset symbol appears at dout.
